tpuv2: RTL

- Second-generation memory-mapped matrix-multiply unit (TPU).
- Computes the DIM x DIM product C = A*B, or C = C + A*B in accumulate mode, over a single-word host bus.
- Adds the following over the first generation: explicit bus strobe, registered reads, a control/status register, busy/done signalling, accumulate mode, write protection while busy, an error flag and a job counter.
- Internally it may reuse the team's A/B operand memories and systolic array; only the behaviour below is normative.

---
 rtl/tpuv2.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tpuv2.sv
// Memory-mapped DIM x DIM signed matrix multiply (C = A*B or C += A*B) with CTRL/STATUS, busy/done and job counter.
// Latency: busy for 3*DIM-2 cycles after the start write; reads return registered data one cycle after the request.
// Backpressure: none; the bus accepts one transaction per cycle, and writes to A/B/C/CTRL while busy are dropped and flag err.
module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             r_w,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int WA      = DIM * BITS_AB / DATAW;
    localparam int WC      = DIM * BITS_C / DATAW;
    localparam int RUN_CYC = 3 * DIM - 2;
    localparam int CW      = $clog2(RUN_CYC + 1);
    localparam int RW      = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int WAW     = (WA > 1) ? $clog2(WA) : 1;
    localparam int WCW     = (WC > 1) ? $clog2(WC) : 1;
    localparam int BS      = $clog2(DATAW / 8);
    localparam int A_BYTES = DIM * WA * (DATAW / 8);
    localparam int C_BYTES = DIM * WC * (DATAW / 8);

    localparam logic [ADDRW-1:0] A_BASE    = ADDRW'('h0100);
    localparam logic [ADDRW-1:0] B_BASE    = ADDRW'('h0200);
    localparam logic [ADDRW-1:0] C_BASE    = ADDRW'('h0300);
    localparam logic [ADDRW-1:0] CTRL_ADDR = ADDRW'('h0400);
    localparam logic [ADDRW-1:0] STAT_ADDR = ADDRW'('h0408);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [DIM*BITS_AB-1:0]  a_q [DIM];
    logic [DIM*BITS_AB-1:0]  b_q [DIM];
    logic [DIM*BITS_C-1:0]   c_q [DIM];
    logic [CW-1:0]           cnt_q;
    logic                    acc_q;
    logic                    done_q;
    logic                    sticky_q;
    logic                    err_q;
    logic [15:0]             jobs_q;
    logic [DATAW-1:0]        dout_q;

    logic                    wr, rd, aligned;
    logic                    hit_a, hit_b, hit_c, hit_ctrl, hit_stat;
    logic [ADDRW-1:0]        off_a, off_b, off_c;
    logic [RW-1:0]           a_row, b_row, c_row, row_idx;
    logic [WAW-1:0]          a_w, b_w;
    logic [WCW-1:0]          c_w;
    logic                    start_go, blocked;
    logic [DATAW-1:0]        rd_data;
    logic [DIM*BITS_C-1:0]   row_new;
    logic [BITS_C-1:0]       sum;
    logic signed [2*BITS_AB-1:0] prod;

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign dataOut = dout_q;
    assign row_idx = cnt_q[RW-1:0];

    // Address decode: word-aligned hits per region plus row/word split inside each region
    always_comb begin
        wr       = en && r_w;
        rd       = en && !r_w;
        aligned  = (addr[BS-1:0] == '0);
        hit_a    = aligned && (addr >= A_BASE) && (addr < A_BASE + ADDRW'(A_BYTES));
        hit_b    = aligned && (addr >= B_BASE) && (addr < B_BASE + ADDRW'(A_BYTES));
        hit_c    = aligned && (addr >= C_BASE) && (addr < C_BASE + ADDRW'(C_BYTES));
        hit_ctrl = (addr == CTRL_ADDR);
        hit_stat = (addr == STAT_ADDR);
        off_a    = (addr - A_BASE) >> BS;
        off_b    = (addr - B_BASE) >> BS;
        off_c    = (addr - C_BASE) >> BS;
        a_row    = RW'(off_a / ADDRW'(WA));
        a_w      = WAW'(off_a % ADDRW'(WA));
        b_row    = RW'(off_b / ADDRW'(WA));
        b_w      = WAW'(off_b % ADDRW'(WA));
        c_row    = RW'(off_c / ADDRW'(WC));
        c_w      = WCW'(off_c % ADDRW'(WC));
        start_go = wr && hit_ctrl && dataIn[0] && (state_q == IDLE);
        blocked  = wr && (state_q == RUN) && (hit_a || hit_b || hit_c || hit_ctrl);
    end

    // Read mux: C only when idle, STATUS always, everything else reads as zero
    always_comb begin
        rd_data = '0;
        if (hit_c && (state_q == IDLE)) begin
            rd_data = c_q[c_row][c_w*DATAW +: DATAW];
        end else if (hit_stat) begin
            rd_data = DATAW'({jobs_q, 8'(DIM), 5'b0, err_q, sticky_q, busy});
        end
    end

    // One full C row per cycle: dot products of A row (cnt) with every B column, optionally on top of old C
    always_comb begin
        row_new = '0;
        sum     = '0;
        prod    = '0;
        for (int j = 0; j < DIM; j++) begin
            sum = acc_q ? c_q[row_idx][j*BITS_C +: BITS_C] : '0;
            for (int k = 0; k < DIM; k++) begin
                prod = $signed(a_q[row_idx][k*BITS_AB +: BITS_AB]) *
                       $signed(b_q[k][j*BITS_AB +: BITS_AB]);
                sum  = sum + BITS_C'(prod);
            end
            row_new[j*BITS_C +: BITS_C] = sum;
        end
    end

    // Next state: start only from IDLE, finish after the fixed run length
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_go) state_d = RUN;
            RUN:  if (cnt_q == CW'(RUN_CYC - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand/result storage, run bookkeeping, status flags and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
                c_q[r] <= '0;
            end
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            jobs_q   <= '0;
            dout_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (wr && hit_a) a_q[a_row][a_w*DATAW +: DATAW] <= dataIn;
                if (wr && hit_b) b_q[b_row][b_w*DATAW +: DATAW] <= dataIn;
                if (wr && hit_c) c_q[c_row][c_w*DATAW +: DATAW] <= dataIn;
                if (wr && hit_ctrl) begin
                    // clear is applied before start so both can share one write
                    if (dataIn[3]) begin
                        sticky_q <= 1'b0;
                        err_q    <= 1'b0;
                    end
                    if (dataIn[0]) begin
                        sticky_q <= 1'b0;
                        acc_q    <= dataIn[1];
                        cnt_q    <= '0;
                    end
                end
            end else begin
                if (blocked) err_q <= 1'b1;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q < CW'(DIM)) c_q[row_idx] <= row_new;
                if (cnt_q == CW'(RUN_CYC - 1)) begin
                    done_q   <= 1'b1;
                    sticky_q <= 1'b1;
                    jobs_q   <= jobs_q + 16'd1;
                end
            end
            if (rd) dout_q <= rd_data;
        end
    end

endmodule
